// File: rtl/logic_pkg.sv
// Shared encodings for the logic-gate pipeline: base-op codes, invert flag
// position and the supported operand-count range.
package logic_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_RSVD = 2'd3
  } base_op_e;

  localparam int INV_BIT    = 2;
  localparam int NUM_IN_MIN = 2;
  localparam int NUM_IN_MAX = 16;

endpackage

// File: rtl/logic_reduce.sv
// Combinational bitwise reduction of NUM_IN operands with one base op.
// The reserved op reduces to zero.
module logic_reduce
  import logic_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
) (
  input  logic [NUM_IN-1:0][WIDTH-1:0] operands_i,
  input  base_op_e                     op_i,
  output logic [WIDTH-1:0]             result_o
);

  always_comb begin
    result_o = operands_i[0];
    for (int k = 1; k < NUM_IN; k++) begin
      case (op_i)
        OP_AND:  result_o = result_o & operands_i[k];
        OP_OR:   result_o = result_o | operands_i[k];
        OP_XOR:  result_o = result_o ^ operands_i[k];
        default: result_o = '0;
      endcase
    end
    if (op_i == OP_RSVD) result_o = '0;
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// Two-stage valid/ready pipeline: stage 1 reduces the operands of a beat,
// stage 2 folds beats into a packet accumulator and emits on the last beat.
module logic_gate_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [2:0]              in_op,
  input  logic                    in_accum,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err
);

  if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX) begin : g_bad_num_in
    $error("logic_gate_pipe: NUM_IN out of range");
  end

  logic [NUM_IN-1:0][WIDTH-1:0] in_ops;
  logic [WIDTH-1:0]             red, fold_raw, fold_val;
  logic [2:0]                   in_gov_op;
  logic                         s2_adv, s1_take, s1_is_last, in_fire;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic             s1_accum_q, s1_accum_d;
  logic             s1_last_q, s1_last_d;
  logic             in_pkt_open_q, in_pkt_open_d;
  logic [2:0]       in_pkt_op_q, in_pkt_op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             pkt_open_q, pkt_open_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_err_q, out_err_d;

  assign in_ops = in_data;

  // Later beats of a packet are reduced with the packet's first-beat op, so
  // the input side tracks packet boundaries independently of stage 2.
  assign in_gov_op = in_pkt_open_q ? in_pkt_op_q : in_op;

  logic_reduce #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) u_reduce (
    .operands_i (in_ops),
    .op_i       (base_op_e'(in_gov_op[1:0])),
    .result_o   (red)
  );

  logic_reduce #(.WIDTH(WIDTH), .NUM_IN(2)) u_fold (
    .operands_i ({acc_q, s1_data_q}),
    .op_i       (base_op_e'(s1_op_q[1:0])),
    .result_o   (fold_raw)
  );

  assign s2_adv     = !out_valid_q || out_ready;
  assign s1_take    = s1_valid_q && s2_adv;
  assign in_ready   = !rst && (!s1_valid_q || s2_adv);
  assign in_fire    = in_valid && in_ready;
  assign s1_is_last = !s1_accum_q || s1_last_q;
  assign fold_val   = pkt_open_q ? fold_raw : s1_data_q;

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_data_d     = s1_data_q;
    s1_op_d       = s1_op_q;
    s1_accum_d    = s1_accum_q;
    s1_last_d     = s1_last_q;
    in_pkt_open_d = in_pkt_open_q;
    in_pkt_op_d   = in_pkt_op_q;
    acc_d         = acc_q;
    pkt_open_d    = pkt_open_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_err_d     = out_err_q;

    if (in_fire) begin
      s1_valid_d    = 1'b1;
      s1_data_d     = red;
      s1_op_d       = in_gov_op;
      s1_accum_d    = in_accum;
      s1_last_d     = in_last;
      in_pkt_open_d = in_accum && !in_last;
      in_pkt_op_d   = in_gov_op;
    end else if (s1_take) begin
      s1_valid_d = 1'b0;
    end

    // Every fold waits for s2_adv, so a stalled result is never overwritten.
    if (s2_adv) begin
      out_valid_d = s1_take && s1_is_last;
      if (s1_take) begin
        if (s1_is_last) begin
          out_data_d = s1_op_q[INV_BIT] ? ~fold_val : fold_val;
          out_err_d  = (s1_op_q[1:0] == OP_RSVD);
          acc_d      = '0;
          pkt_open_d = 1'b0;
        end else begin
          acc_d      = fold_val;
          pkt_open_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_data_q     <= '0;
      s1_op_q       <= '0;
      s1_accum_q    <= 1'b0;
      s1_last_q     <= 1'b0;
      in_pkt_open_q <= 1'b0;
      in_pkt_op_q   <= '0;
      acc_q         <= '0;
      pkt_open_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_err_q     <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_data_q     <= s1_data_d;
      s1_op_q       <= s1_op_d;
      s1_accum_q    <= s1_accum_d;
      s1_last_q     <= s1_last_d;
      in_pkt_open_q <= in_pkt_open_d;
      in_pkt_op_q   <= in_pkt_op_d;
      acc_q         <= acc_d;
      pkt_open_q    <= pkt_open_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_err_q     <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule

// File: doc/logic_gate_pipe.md
LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each operand and of the result.
REQ-002 Parameter NUM_IN, default 4: number of operands per beat, range 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  beat offered.
REQ-006 in_ready  output  1  beat accepted when in_valid && in_ready at a clk edge.
REQ-007 in_data  input  NUM_IN*WIDTH  operand k occupies bits [k*WIDTH +: WIDTH].
REQ-008 in_op  input  3  [1:0] base op (0 AND, 1 OR, 2 XOR, 3 reserved); [2] invert result.
REQ-009 in_accum  input  1  beat belongs to a multi-beat accumulation packet.
REQ-010 in_last  input  1  final beat of a packet; ignored when in_accum=0.
REQ-011 out_valid  output  1  result offered.
REQ-012 out_ready  input  1  result consumed when out_valid && out_ready at a clk edge.
REQ-013 out_data  output  WIDTH  result.
REQ-014 out_err  output  1  result was produced with reserved base op.

Function
REQ-015 Stage 1 SHALL register the bitwise base-op reduction across all NUM_IN operands, plus op, accum and last flags.
REQ-016 Stage 2 SHALL fold the stage-1 value into the accumulator with the base op, apply inversion at emit only, and drive out_* from registers.
REQ-017 Non-accumulating beat (in_accum=0) SHALL appear on out_data exactly 2 cycles after acceptance when out_ready is held high.
REQ-018 Each stage SHALL advance when it is empty or its downstream stage advances; in_ready = !s1_valid || s2_advance, and s2_advance = !out_valid || out_ready (a combinational path from out_ready to in_ready is permitted).
REQ-019 With out_ready held high, throughput SHALL be one beat per cycle; with out_ready low, no beat SHALL be lost or duplicated, and out_data/out_err SHALL remain stable while out_valid=1.
REQ-020 Accumulation packet: beats with in_accum=1, in_last=0 SHALL fold into the accumulator without asserting out_valid; the in_accum=1, in_last=1 beat SHALL fold and emit, then the accumulator SHALL clear.
REQ-021 The op of the first beat of a packet SHALL govern the whole packet; in_op on later beats SHALL be ignored.
REQ-022 Single-beat packet (in_accum=1, in_last=1 on first beat) SHALL behave identically to in_accum=0.
REQ-023 Reserved base op SHALL yield out_data = 0 (before inversion, so all ones with invert set) and out_err=1 on the emitting beat; for packets, out_err SHALL be set if the packet's governing op is reserved.
REQ-024 A packet's emitted result SHALL not be overwritten while it is stalled: the next packet's first fold SHALL wait for s2_advance.

Reset
REQ-025 While rst=1: out_valid=0, out_data=0, out_err=0, in_ready=0, both stages empty, accumulator cleared, packet-open flag cleared.
REQ-026 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-027 Reset mid-packet or mid-stall SHALL discard all partial state; the first beat after reset SHALL start a new packet.

Structure
REQ-028 Shared package logic_pkg SHALL hold the op encoding (OP_AND, OP_OR, OP_XOR, OP_RSVD), the invert bit index and the NUM_IN range limits.
REQ-029 The combinational N-operand reduction SHALL be a sub-module named logic_reduce (parameters WIDTH, NUM_IN; inputs operands and base op; output WIDTH result).

Verification (WIDTH=8, NUM_IN=4)
REQ-030 Operands 0x0F,0xF0,0x33,0xCC, op=1 (OR), out_ready=1 -> out_data=0xFF, out_err=0, 2 cycles after acceptance; op=5 (NOR) -> 0x00.
REQ-031 Same operands, op=2 (XOR) -> 0x00; operands 0x01,0x02,0x04,0x08, op=6 (XNOR) -> 0xF0.
REQ-032 Packet of 3 beats, op=0 (AND), beat reductions 0xFF,0x7E,0x3C, last on beat 3 -> single out_valid with out_data=0x3C; op changed to 1 on beat 2 -> result unchanged.
REQ-033 Back-to-back 6 beats with out_ready low for 4 cycles mid-stream -> in_ready drops, all 6 results delivered in order, no duplicates, out_data stable during stall.
REQ-034 op=3 -> out_data=0x00, out_err=1; op=7 -> out_data=0xFF, out_err=1.
REQ-035 rst asserted after beat 2 of a 3-beat AND packet -> out_valid=0 immediately; next single beat 0xAA x4 with op=0 -> out_data=0xAA, with no influence from the partial packet.
